// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared state encoding and default widths for the DMEM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module   : dmem_arbiter_if
// Purpose  : Two requester ports plus the DMEM port of the arbiter.
//            slave modport = arbiter side, master modport = environment side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              P0_req;
    logic              P0_we;
    logic [ADDR_W-1:0] P0_addr;
    logic [DATA_W-1:0] P0_wdata;
    logic              P0_ack;
    logic [DATA_W-1:0] P0_rdata;

    logic              P1_req;
    logic              P1_we;
    logic [ADDR_W-1:0] P1_addr;
    logic [DATA_W-1:0] P1_wdata;
    logic              P1_ack;
    logic [DATA_W-1:0] P1_rdata;

    logic [ADDR_W-1:0] DMEM_address;
    logic [DATA_W-1:0] DMEM_data_in;
    logic              DMEM_mem_write;
    logic              DMEM_mem_read;
    logic [DATA_W-1:0] DMEM_data_out;

    logic              ARB_busy;

    modport slave (
        input  P0_req, P0_we, P0_addr, P0_wdata,
        input  P1_req, P1_we, P1_addr, P1_wdata,
        input  DMEM_data_out,
        output P0_ack, P0_rdata, P1_ack, P1_rdata,
        output DMEM_address, DMEM_data_in, DMEM_mem_write, DMEM_mem_read,
        output ARB_busy
    );

    modport master (
        output P0_req, P0_we, P0_addr, P0_wdata,
        output P1_req, P1_we, P1_addr, P1_wdata,
        output DMEM_data_out,
        input  P0_ack, P0_rdata, P1_ack, P1_rdata,
        input  DMEM_address, DMEM_data_in, DMEM_mem_write, DMEM_mem_read,
        input  ARB_busy
    );

endinterface

`default_nettype wire

// File: rtl/arb_grant2.sv
// ============================================================================
// Module   : arb_grant2
// Purpose  : Two-way one-hot grant. ptr=0 gives port 0 priority on a tie,
//            ptr=1 gives port 1 priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_grant2 (
    input  wire logic       req0,
    input  wire logic       req1,
    input  wire logic       ptr,
    output logic [1:0]      grant
);

    // Tie resolved by the pointer; a lone request always wins.
    always_comb begin
        grant = 2'b00;
        if (req0 && req1) begin
            grant = ptr ? 2'b10 : 2'b01;
        end else if (req0) begin
            grant = 2'b01;
        end else if (req1) begin
            grant = 2'b10;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Arbitrates CPU port (P0) and debug/DMA port (P1) onto one DMEM
//            port. IDLE -> ACCESS -> RESP -> IDLE, ack two cycles after the
//            request is sampled in IDLE.
// Config   : DMEM_ARB_ROUND_ROBIN_EN - defined: alternate on ties;
//            undefined: port 0 always wins ties, no pointer register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic      DMEM_ARB_clk,
    input  wire logic      DMEM_ARB_rst_n,
    dmem_arbiter_if.slave  bus
);

    arb_state_t        state_q, state_d;
    logic              gnt_q,   gnt_d;     // 0 = port 0 owns the access
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              ack0_q,  ack0_d;
    logic              ack1_q,  ack1_d;
    logic              busy_q,  busy_d;
    logic              ptr;
    logic [1:0]        grant;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    assign ptr = 1'b0;
`endif

    arb_grant2 u_grant (
        .req0  (bus.P0_req),
        .req1  (bus.P1_req),
        .ptr   (ptr),
        .grant (grant)
    );

    // Next-state and next-output computation for the access FSM.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mem_rd_d = mem_rd_q;
        mem_wr_d = mem_wr_q;
        ack0_d   = ack0_q;
        ack1_d   = ack1_q;
        busy_d   = busy_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                // Payload is captured only here; later changes are ignored.
                if (grant != 2'b00) begin
                    gnt_d    = grant[1];
                    we_d     = grant[1] ? bus.P1_we    : bus.P0_we;
                    addr_d   = grant[1] ? bus.P1_addr  : bus.P0_addr;
                    wdata_d  = grant[1] ? bus.P1_wdata : bus.P0_wdata;
                    mem_wr_d = grant[1] ? bus.P1_we    : bus.P0_we;
                    mem_rd_d = grant[1] ? !bus.P1_we   : !bus.P0_we;
                    busy_d   = 1'b1;
                    state_d  = ACCESS;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                    ptr_d    = !grant[1];
`endif
                end
            end
            ACCESS: begin
                // Strobes have been seen by DMEM for one edge; respond next.
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
                ack0_d   = !gnt_q;
                ack1_d   = gnt_q;
                state_d  = RESP;
            end
            RESP: begin
                ack0_d   = 1'b0;
                ack1_d   = 1'b0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
                ack0_d   = 1'b0;
                ack1_d   = 1'b0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge DMEM_ARB_clk or negedge DMEM_ARB_rst_n) begin
        if (!DMEM_ARB_rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            ptr_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            busy_q   <= busy_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign bus.DMEM_address   = addr_q;
    assign bus.DMEM_data_in   = wdata_q;
    assign bus.DMEM_mem_read  = mem_rd_q;
    assign bus.DMEM_mem_write = mem_wr_q;
    assign bus.ARB_busy       = busy_q;
    assign bus.P0_ack         = ack0_q;
    assign bus.P1_ack         = ack1_q;
    // DMEM data is already registered inside DMEM; only gate it to the owner.
    assign bus.P0_rdata       = (ack0_q && !we_q) ? bus.DMEM_data_out : '0;
    assign bus.P1_rdata       = (ack1_q && !we_q) ? bus.DMEM_data_out : '0;

endmodule

`default_nettype wire
